// File: rtl/ov_cam_pkg.sv
// ov_cam_pkg: shared camera/framebuffer geometry, capture FSM states and RGB565 layout
package ov_cam_pkg;
    localparam int H_ACTIVE  = 320;
    localparam int V_ACTIVE  = 240;
    localparam int FB_ADDR_W = 17;
    localparam int FB_DEPTH  = H_ACTIVE * V_ACTIVE;

    typedef enum logic [1:0] {WAIT_FRAME, WAIT_VS_LOW, CAPTURE} cap_state_t;

    // RGB565 field layout, shared with the upscaler: r[15:11], g[10:5], b[4:0]
    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;
endpackage

// File: rtl/ov_fb_writer_if.sv
// ov_fb_writer_if: OV2640 DVP input bus plus framebuffer write port
// master: the capture writer (reads cam_*, drives fb_*); slave: camera model / framebuffer side
interface ov_fb_writer_if #(
    parameter int ADDR_W = ov_cam_pkg::FB_ADDR_W
) ();
    import ov_cam_pkg::*;
    logic              cam_pclk;
    logic              cam_href;
    logic              cam_vsync;
    logic [7:0]        cam_data;
    logic              fb_wr_en;
    logic [ADDR_W-1:0] fb_wr_addr;
    rgb565_t           fb_wr_data;

    modport master (
        input  cam_pclk, cam_href, cam_vsync, cam_data,
        output fb_wr_en, fb_wr_addr, fb_wr_data
    );
    modport slave (
        output cam_pclk, cam_href, cam_vsync, cam_data,
        input  fb_wr_en, fb_wr_addr, fb_wr_data
    );
endinterface

// File: rtl/cam_sync_edge.sv
// cam_sync_edge: W-bit 2-FF synchronizer with rise/fall pulses on the synced value
// vga_clk/rst_n: clock and sync active-low reset; i_d: async input; o_q: synced; o_rise/o_fall: 1-cycle edges
module cam_sync_edge #(
    parameter int W = 1
) (
    input  logic         vga_clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q,
    output logic [W-1:0] o_rise,
    output logic [W-1:0] o_fall
);
    logic [W-1:0] r_s1, r_s2, r_prev;

    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_prev <= '0;
        end else begin
            r_s1   <= i_d;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign o_q    = r_s2;
    assign o_rise = r_s2 & ~r_prev;
    assign o_fall = ~r_s2 & r_prev;
endmodule

// File: rtl/ov_fb_writer.sv
// ov_fb_writer: oversamples the OV2640 DVP bus and writes RGB565 pixels into the framebuffer
// vga_clk/rst_n: clock, sync active-low reset; capture_en: arm capture of following frames;
// bus: DVP inputs and fb write port; frame_done/frame_err: 1-cycle close pulses; busy: in CAPTURE
module ov_fb_writer #(
    parameter int H_ACTIVE = ov_cam_pkg::H_ACTIVE,
    parameter int V_ACTIVE = ov_cam_pkg::V_ACTIVE,
    parameter int ADDR_W   = ov_cam_pkg::FB_ADDR_W
) (
    input  logic           vga_clk,
    input  logic           rst_n,
    input  logic           capture_en,
    ov_fb_writer_if.master bus,
    output logic           frame_done,
    output logic           frame_err,
    output logic           busy
);
    import ov_cam_pkg::*;

    localparam int X_W = $clog2(H_ACTIVE + 1);
    localparam int Y_W = $clog2(V_ACTIVE + 1);
    localparam logic [X_W-1:0]    X_END = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]    Y_END = Y_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] LINE  = ADDR_W'(H_ACTIVE);

    logic [7:0] w_data, w_data_rise, w_data_fall;
    logic w_pclk, w_pclk_rise, w_pclk_fall;
    logic w_href, w_href_rise, w_href_fall;
    logic w_vs, w_vs_rise, w_vs_fall;
    logic w_start, w_close;
    logic w_unused;
    cap_state_t r_state, w_next;

    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [ADDR_W-1:0] r_addr, r_base, r_wr_addr;
    logic [7:0]        r_hi;
    logic              r_phase, r_err, r_line, r_wr_en, r_done, r_ferr;
    rgb565_t           r_wr_data;

    // data goes through the same depth as pclk so it is stable at the sample event
    cam_sync_edge #(.W(1)) u_pclk (.vga_clk(vga_clk), .rst_n(rst_n), .i_d(bus.cam_pclk),
        .o_q(w_pclk), .o_rise(w_pclk_rise), .o_fall(w_pclk_fall));
    cam_sync_edge #(.W(1)) u_href (.vga_clk(vga_clk), .rst_n(rst_n), .i_d(bus.cam_href),
        .o_q(w_href), .o_rise(w_href_rise), .o_fall(w_href_fall));
    cam_sync_edge #(.W(1)) u_vsync (.vga_clk(vga_clk), .rst_n(rst_n), .i_d(bus.cam_vsync),
        .o_q(w_vs), .o_rise(w_vs_rise), .o_fall(w_vs_fall));
    cam_sync_edge #(.W(8)) u_data (.vga_clk(vga_clk), .rst_n(rst_n), .i_d(bus.cam_data),
        .o_q(w_data), .o_rise(w_data_rise), .o_fall(w_data_fall));

    assign w_unused = &{1'b0, w_pclk, w_pclk_fall, w_href_rise, w_href_fall, w_vs,
                        w_data_rise, w_data_fall};

    always_ff @(posedge vga_clk) begin
        if (!rst_n) r_state <= WAIT_FRAME;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_close = 1'b0;
        case (r_state)
            WAIT_FRAME:  if (w_vs_rise && capture_en) w_next = WAIT_VS_LOW;
            WAIT_VS_LOW: if (w_vs_fall) begin
                w_next  = CAPTURE;
                w_start = 1'b1;
            end
            CAPTURE:     if (w_vs_rise) begin
                w_close = 1'b1;
                w_next  = capture_en ? WAIT_VS_LOW : WAIT_FRAME;
            end
            default:     w_next = WAIT_FRAME;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            r_x       <= '0;
            r_y       <= '0;
            r_addr    <= '0;
            r_base    <= '0;
            r_hi      <= '0;
            r_phase   <= 1'b0;
            r_err     <= 1'b0;
            r_line    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
            if (w_start) begin
                r_x     <= '0;
                r_y     <= '0;
                r_addr  <= '0;
                r_base  <= '0;
                r_phase <= 1'b0;
                r_err   <= 1'b0;
                r_line  <= 1'b0;
            end else if (w_close) begin
                // frame close wins over a coincident sample; that pixel is dropped
                r_done <= (r_y == Y_END) && !r_err;
                r_ferr <= !((r_y == Y_END) && !r_err);
            end else if (r_state == CAPTURE && w_pclk_rise) begin
                if (w_href) begin
                    r_line <= 1'b1;
                    if (!r_phase) begin
                        r_hi    <= w_data;
                        r_phase <= 1'b1;
                    end else begin
                        r_phase <= 1'b0;
                        if (r_x < X_END && r_y < Y_END) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_addr;
                            r_wr_data <= rgb565_t'({r_hi, w_data});
                            r_addr    <= r_addr + 1'b1;
                            r_x       <= r_x + 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end else if (r_line) begin
                    // first href-low sample after an active line closes it; a dangling hi byte is dropped
                    r_line  <= 1'b0;
                    r_x     <= '0;
                    r_phase <= 1'b0;
                    if (r_x != X_END || r_phase) r_err <= 1'b1;
                    if (r_y < Y_END) begin
                        r_y    <= r_y + 1'b1;
                        r_base <= r_base + LINE;
                        r_addr <= r_base + LINE;
                    end
                end
            end
        end
    end

    assign bus.fb_wr_en   = r_wr_en;
    assign bus.fb_wr_addr = r_wr_addr;
    assign bus.fb_wr_data = r_wr_data;
    assign frame_done     = r_done;
    assign frame_err      = r_ferr;
    assign busy           = (r_state == CAPTURE);
endmodule

// File: tb/tb_ov_fb_writer.sv
// tb_ov_fb_writer: directed DVP frames on a reduced 8x8 geometry with hand-computed expectations
module tb_ov_fb_writer;
    localparam int H = 8;
    localparam int V = 8;

    logic vga_clk = 1'b0;
    logic rst_n = 1'b0;
    logic capture_en = 1'b0;
    logic frame_done, frame_err, busy;

    ov_fb_writer_if #(.ADDR_W(17)) bus ();

    ov_fb_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(17)) dut (
        .vga_clk(vga_clk),
        .rst_n(rst_n),
        .capture_en(capture_en),
        .bus(bus),
        .frame_done(frame_done),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #20 vga_clk = ~vga_clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_wr, n_fd, n_fe, n_bad, max_addr, first_wr, g_k;
    int cnt [0:127];
    logic [15:0] mem [0:127];

    always @(posedge vga_clk) cyc++;

    always @(negedge vga_clk) begin
        if (bus.fb_wr_en) begin
            n_wr++;
            if (!busy) n_bad++;
            if (int'(bus.fb_wr_addr) > max_addr) max_addr = int'(bus.fb_wr_addr);
            if (first_wr < 0) first_wr = cyc;
            if (bus.fb_wr_addr < 17'd128) begin
                cnt[bus.fb_wr_addr[6:0]]++;
                mem[bus.fb_wr_addr[6:0]] = bus.fb_wr_data;
            end
        end
        if (frame_done) n_fd++;
        if (frame_err) n_fe++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_sb();
        n_wr = 0; n_fd = 0; n_fe = 0; max_addr = -1; first_wr = -1;
        for (int i = 0; i < 128; i++) begin
            cnt[i] = 0;
            mem[i] = 16'hxxxx;
        end
    endtask

    task automatic cam_byte(input logic [7:0] b);
        bus.cam_data = b;
        bus.cam_href = 1'b1;
        @(negedge vga_clk);
        bus.cam_pclk = 1'b1;
        repeat (2) @(negedge vga_clk);
        bus.cam_pclk = 1'b0;
        @(negedge vga_clk);
    endtask

    task automatic cam_idle(input int n);
        bus.cam_href = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.cam_pclk = 1'b1;
            repeat (2) @(negedge vga_clk);
            bus.cam_pclk = 1'b0;
            repeat (2) @(negedge vga_clk);
        end
    endtask

    task automatic cam_line(input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            cam_byte(8'(g_k));
            g_k++;
        end
        cam_idle(2);
    endtask

    task automatic vs_pulse();
        bus.cam_vsync = 1'b1;
        cam_idle(3);
        bus.cam_vsync = 1'b0;
        cam_idle(3);
    endtask

    function automatic int bad_addrs(input int n);
        int b = 0;
        for (int i = 0; i < n; i++) if (cnt[i] != 1) b++;
        return b;
    endfunction

    initial begin
        int r2;
        bus.cam_pclk = 1'b0; bus.cam_href = 1'b0; bus.cam_vsync = 1'b0; bus.cam_data = 8'h00;
        n_bad = 0;
        clr_sb();
        repeat (4) @(negedge vga_clk);
        check("rst_wr_en", 32'(bus.fb_wr_en), 0);
        check("rst_addr", 32'(bus.fb_wr_addr), 0);
        check("rst_data", 32'(bus.fb_wr_data), 0);
        check("rst_done", 32'(frame_done), 0);
        check("rst_err", 32'(frame_err), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        capture_en = 1'b1;
        vs_pulse();
        check("busy_capture", 32'(busy), 1);
        clr_sb();

        // nominal frame
        g_k = 0;
        for (int y = 0; y < V; y++) cam_line(2 * H);
        vs_pulse();
        check("nom_writes", n_wr, 64);
        check("nom_addr_once", bad_addrs(64), 0);
        check("nom_max_addr", max_addr, 63);
        check("nom_data0", 32'(mem[0]), 32'h0001);
        check("nom_data9", 32'(mem[9]), 32'h1213);
        check("nom_data63", 32'(mem[63]), 32'h7e7f);
        check("nom_done", n_fd, 1);
        check("nom_err", n_fe, 0);
        clr_sb();

        // short line 5
        g_k = 0;
        for (int y = 0; y < V; y++) cam_line(y == 5 ? 2 * H - 2 : 2 * H);
        vs_pulse();
        check("short_writes", n_wr, 63);
        check("short_tail_cnt", cnt[47], 0);
        check("short_l5_cnt", cnt[40], 1);
        check("short_l6_cnt", cnt[48], 1);
        check("short_l6_data", 32'(mem[48]), 32'h5e5f);
        check("short_done", n_fd, 0);
        check("short_err", n_fe, 1);
        clr_sb();

        // long line 0, odd line 1
        g_k = 0;
        for (int y = 0; y < V; y++) cam_line(y == 0 ? 2 * H + 2 : y == 1 ? 2 * H + 1 : 2 * H);
        vs_pulse();
        check("long_writes", n_wr, 64);
        check("long_addr_once", bad_addrs(64), 0);
        check("long_max_addr", max_addr, 63);
        check("long_l1_data", 32'(mem[8]), 32'h1213);
        check("odd_l2_data", 32'(mem[16]), 32'h2324);
        check("long_done", n_fd, 0);
        check("long_err", n_fe, 1);

        // mid-frame enable and reset
        capture_en = 1'b0;
        vs_pulse();
        check("idle_busy", 32'(busy), 0);
        clr_sb();
        capture_en = 1'b1;
        g_k = 0;
        for (int y = 0; y < 2; y++) cam_line(2 * H);
        check("mid_start_writes", n_wr, 0);
        vs_pulse();
        clr_sb();
        g_k = 0;
        for (int y = 0; y < 2; y++) cam_line(2 * H);
        check("pre_rst_writes", n_wr, 16);
        rst_n = 1'b0;
        @(negedge vga_clk);
        rst_n = 1'b1;
        check("arst_wr_en", 32'(bus.fb_wr_en), 0);
        check("arst_addr", 32'(bus.fb_wr_addr), 0);
        check("arst_data", 32'(bus.fb_wr_data), 0);
        check("arst_done", 32'(frame_done), 0);
        check("arst_err", 32'(frame_err), 0);
        check("arst_busy", 32'(busy), 0);
        clr_sb();
        for (int y = 2; y < V; y++) cam_line(2 * H);
        check("post_rst_writes", n_wr, 0);
        vs_pulse();
        check("abort_pulses", n_fd + n_fe, 0);
        clr_sb();

        // capture_en drop during line 4
        g_k = 0;
        for (int y = 0; y < 4; y++) cam_line(2 * H);
        for (int i = 0; i < H; i++) begin
            cam_byte(8'(g_k));
            g_k++;
        end
        capture_en = 1'b0;
        for (int i = 0; i < H; i++) begin
            cam_byte(8'(g_k));
            g_k++;
        end
        cam_idle(2);
        for (int y = 5; y < V; y++) cam_line(2 * H);
        vs_pulse();
        check("drop_writes", n_wr, 64);
        check("drop_done", n_fd, 1);
        check("drop_err", n_fe, 0);
        check("drop_busy", 32'(busy), 0);
        clr_sb();
        g_k = 0;
        for (int y = 0; y < V; y++) cam_line(2 * H);
        vs_pulse();
        check("off_writes", n_wr, 0);
        check("off_pulses", n_fd + n_fe, 0);

        // write latency relative to raw pclk edges at cycles 10 and 14
        capture_en = 1'b1;
        vs_pulse();
        clr_sb();
        bus.cam_data = 8'h3c;
        bus.cam_href = 1'b1;
        repeat (10) @(negedge vga_clk);
        bus.cam_pclk = 1'b1;
        repeat (2) @(negedge vga_clk);
        bus.cam_pclk = 1'b0;
        bus.cam_data = 8'hc3;
        repeat (2) @(negedge vga_clk);
        bus.cam_pclk = 1'b1;
        r2 = cyc;
        repeat (2) @(negedge vga_clk);
        bus.cam_pclk = 1'b0;
        repeat (10) @(negedge vga_clk);
        check("lat_count", n_wr, 1);
        check("lat_data", 32'(mem[0]), 32'h3cc3);
        check("lat_delay_3to4", 32'(first_wr - r2 >= 3 && first_wr - r2 <= 4), 1);
        cam_idle(2);
        check("wr_outside_capture", n_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
